// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   full 16-key image across consecutive scans and reports each clean
//   single-key press as a one-cycle strobe with a 4-bit hex code.
//
// Ports
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   rows      : keypad rows, active-low, pulled up, asynchronous to clk
//   cols      : column drive, active-low, exactly one bit low
//   key_code  : code {column, row} of the last accepted key, held until next
//   key_valid : one-cycle strobe when a new key is accepted
//   key_held  : high while the debounced image has any key pressed
//
// Internal images are pressed-high, bit index {column[1:0], row[1:0]}, where
// row 0 is rows[3] and row 3 is rows[0].
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 32768,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    r_sync1, r_sync2;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [3:0]    r_cols;
    logic [15:0]   r_scan, r_prev, r_deb;
    logic [SW-1:0] r_stable;
    logic          r_scan_done;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_held;

    logic          w_sample;
    logic [3:0]    w_col_bits;
    logic          w_same;
    logic [SW-1:0] w_stable_inc;
    logic [SW-1:0] w_stable_nxt;
    logic          w_update;
    logic          w_strobe;

    function automatic logic f_is_onehot(input logic [15:0] img);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (img[i]) n = n + 1;
        end
        return (n == 1);
    endfunction

    function automatic logic [3:0] f_encode(input logic [15:0] img);
        logic [3:0] code;
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (img[i]) code = 4'(i);
        end
        return code;
    endfunction

    // Sample only on the last dwell cycle so the column drive has settled.
    assign w_sample   = (r_dwell == DWELL_LAST);
    // Row r maps to rows[3-r]; invert to pressed-high.
    assign w_col_bits = ~{r_sync2[0], r_sync2[1], r_sync2[2], r_sync2[3]};

    assign w_same       = (r_scan == r_prev);
    assign w_stable_inc = (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);
    assign w_stable_nxt = w_same ? w_stable_inc : '0;
    assign w_update     = r_scan_done && (w_stable_nxt == STABLE_MAX) && (r_scan != r_deb);
    // Only an idle-to-single-key transition produces a strobe.
    assign w_strobe     = w_update && (r_deb == 16'h0) && f_is_onehot(r_scan);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= 4'hF;
            r_sync2     <= 4'hF;
            r_dwell     <= '0;
            r_col       <= 2'd0;
            r_cols      <= 4'b0111;
            r_scan      <= 16'h0;
            r_prev      <= 16'h0;
            r_deb       <= 16'h0;
            r_stable    <= '0;
            r_scan_done <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_sync1     <= rows;
            r_sync2     <= r_sync1;
            r_key_valid <= 1'b0;

            if (w_sample) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                r_cols  <= {r_cols[0], r_cols[3:1]};
                case (r_col)
                    2'd0:    r_scan[3:0]   <= w_col_bits;
                    2'd1:    r_scan[7:4]   <= w_col_bits;
                    2'd2:    r_scan[11:8]  <= w_col_bits;
                    default: r_scan[15:12] <= w_col_bits;
                endcase
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end

            // Full image is complete after the column-3 sample; judge it next cycle.
            r_scan_done <= w_sample && (r_col == 2'd3);

            if (r_scan_done) begin
                r_stable <= w_stable_nxt;
                r_prev   <= r_scan;
                if (w_update) begin
                    r_deb      <= r_scan;
                    r_key_held <= |r_scan;
                end
                if (w_strobe) begin
                    r_key_code  <= f_encode(r_scan);
                    r_key_valid <= 1'b1;
                end
            end
        end
    end

    assign cols      = r_cols;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=2. A keypad model
//   pulls rows low for pressed keys in the driven column. Expected key codes
//   are queued when presses are applied and popped on each key_valid strobe.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 2;
    localparam int SCAN_LEN = 4 * SCAN_DIV;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;

    int n_cmp;
    int n_err;
    int exp_q[$];

    // monitor state
    logic [3:0] last_cols;
    logic       last_kv;
    logic [3:0] last_code;
    int         age;
    int         scan_ends;
    logic       timing_en;
    int         timing_base;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: key bit {c,r} shorts row r (rows[3-r]) to column c (cols[3-c]).
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!cols[3-c] && keys[c*4+r]) rows[3-r] = 1'b0;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe scoreboard and output-property monitor.
    initial begin
        last_cols = 4'b0111;
        last_kv   = 1'b0;
        last_code = 4'h0;
        age       = 0;
        scan_ends = 0;
        forever begin
            @(negedge clk);
            if (cols != last_cols) age = 1;
            else                   age = age + 1;
            if (last_cols == 4'b1110 && cols == 4'b0111) scan_ends = scan_ends + 1;
            last_cols = cols;
            if (reset) begin
                last_code = 4'h0;
                last_kv   = 1'b0;
            end else begin
                if (key_valid) begin
                    chk_eq("kv_not_back_to_back", {31'd0, last_kv}, 0);
                    chk_eq("strobe_was_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0) begin
                        chk_eq("strobe_code", {28'd0, key_code}, exp_q.pop_front());
                    end
                    chk_eq("held_at_strobe", {31'd0, key_held}, 1);
                    if (timing_en) begin
                        chk_eq("strobe_cycle_in_scan", age, 2);
                        chk_eq("strobe_scan_count", scan_ends - timing_base, 3);
                        timing_en = 1'b0;
                    end
                    last_code = key_code;
                end else begin
                    chk_eq("code_hold", {28'd0, key_code}, {28'd0, last_code});
                end
                last_kv = key_valid;
            end
        end
    end

    task automatic wait_scan_start();
        logic [3:0] prev;
        logic       found;
        prev  = cols;
        found = 1'b0;
        for (int n = 0; n < 4 * SCAN_LEN && !found; n++) begin
            @(negedge clk);
            #2;
            if (prev == 4'b1110 && cols == 4'b0111) found = 1'b1;
            prev = cols;
        end
        if (!found) chk_eq("scan_start_timeout", 0, 1);
    endtask

    task automatic wait_held(input logic val);
        for (int n = 0; n < 10 * SCAN_LEN && key_held !== val; n++) begin
            @(negedge clk);
            #2;
        end
        chk_eq("held_wait", {31'd0, key_held}, {31'd0, val});
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 10 * SCAN_LEN && exp_q.size() != 0; n++) begin
            @(negedge clk);
            #2;
        end
        chk_eq("strobe_arrived", exp_q.size(), 0);
    endtask

    task automatic hold_scans(input int n);
        repeat (n * SCAN_LEN) @(negedge clk);
        #2;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        logic       any_held;
        n_cmp     = 0;
        n_err     = 0;
        keys      = 16'h0;
        timing_en = 1'b0;
        timing_base = 0;
        reset     = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_eq("rst_cols", {28'd0, cols}, 32'h7);
        chk_eq("rst_code", {28'd0, key_code}, 0);
        chk_eq("rst_valid", {31'd0, key_valid}, 0);
        chk_eq("rst_held", {31'd0, key_held}, 0);

        // Rotation: each column exactly SCAN_DIV cycles from the release.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            e = 4'b1111;
            e[3 - ((k / SCAN_DIV) % 4)] = 1'b0;
            chk_eq("rotation", {28'd0, cols}, {28'd0, e});
            @(negedge clk);
        end
        any_held = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (key_held) any_held = 1'b1;
        end
        chk_eq("idle_no_held", {31'd0, any_held}, 0);

        // Two keys (0,0) and (3,3) from idle: held, no strobe.
        wait_scan_start();
        keys = 16'h8001;
        hold_scans(10);
        chk_eq("two_keys_held", {31'd0, key_held}, 1);
        chk_eq("two_keys_code", {28'd0, key_code}, 0);
        keys = 16'h0001;
        hold_scans(10);
        chk_eq("multi_to_single_held", {31'd0, key_held}, 1);
        chk_eq("multi_to_single_code", {28'd0, key_code}, 0);
        keys = 16'h0;
        wait_held(1'b0);

        // Single press of (1,2) with exact strobe timing.
        wait_scan_start();
        keys        = 16'h0040;
        timing_base = scan_ends;
        timing_en   = 1'b1;
        exp_q.push_back(6);
        hold_scans(10);
        chk_eq("single_held", {31'd0, key_held}, 1);
        chk_eq("single_drained", exp_q.size(), 0);
        chk_eq("single_timing_seen", {31'd0, timing_en}, 0);
        // Release: held drops one cycle after the 3rd released scan ends.
        wait_scan_start();
        keys = 16'h0;
        wait_scan_start();
        wait_scan_start();
        wait_scan_start();
        chk_eq("release_held_before", {31'd0, key_held}, 1);
        @(negedge clk);
        #2;
        chk_eq("release_held_after", {31'd0, key_held}, 0);

        // Bounce: toggle every 5 cycles for 100 cycles, then solid.
        exp_q.push_back(6);
        for (int k = 0; k < 20; k++) begin
            keys[6] = ~keys[6];
            repeat (5) @(negedge clk);
        end
        keys = 16'h0040;
        hold_scans(10);
        chk_eq("bounce_held", {31'd0, key_held}, 1);
        chk_eq("bounce_drained", exp_q.size(), 0);
        keys = 16'h0;
        wait_held(1'b0);

        // Repress key F twice; long hold adds no strobes.
        keys = 16'h8000;
        exp_q.push_back(15);
        hold_scans(10);
        chk_eq("repress1_drained", exp_q.size(), 0);
        keys = 16'h0;
        wait_held(1'b0);
        keys = 16'h8000;
        exp_q.push_back(15);
        hold_scans(50);
        chk_eq("repress2_drained", exp_q.size(), 0);
        chk_eq("repress2_code", {28'd0, key_code}, 15);
        keys = 16'h0;
        wait_held(1'b0);

        // Reset mid-scan during column 2 with key 6 held.
        keys = 16'h0040;
        exp_q.push_back(6);
        wait_drain();
        for (int n = 0; n < 2 * SCAN_LEN && cols != 4'b1101; n++) begin
            @(negedge clk);
        end
        chk_eq("reached_col2", {28'd0, cols}, 32'hD);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_eq("async_rst_cols", {28'd0, cols}, 32'h7);
        chk_eq("async_rst_valid", {31'd0, key_valid}, 0);
        chk_eq("async_rst_held", {31'd0, key_held}, 0);
        chk_eq("async_rst_code", {28'd0, key_code}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(6);
        wait_drain();
        hold_scans(10);
        chk_eq("post_rst_held", {31'd0, key_held}, 1);
        chk_eq("post_rst_code", {28'd0, key_code}, 6);

        chk_eq("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
